// File: rtl/vertex_fetch_if.sv
// Bus bundle between the draw-call front end and its BRAMs / vertex shader.
// The slave modport is the vertex_fetch view; the master modport is the driving environment.
interface vertex_fetch_if #(
    parameter int INDEX_DEPTH  = 4096,
    parameter int VERTEX_DEPTH = 4096
);
    localparam int IA = $clog2(INDEX_DEPTH);
    localparam int VA = $clog2(VERTEX_DEPTH);

    logic                   start_in;
    logic [IA:0]            index_count_in;
    logic [3:0][3:0][31:0]  matrix_in;
    logic                   ready_in;
    logic [IA-1:0]          idx_addr_out;
    logic [VA-1:0]          idx_data_in;
    logic [VA-1:0]          vtx_addr_out;
    logic [203:0]           vtx_data_in;
    logic                   col_set_out;
    logic [3:0][31:0]       col_out;
    logic                   valid_out;
    logic [2:0][31:0]       position_out;
    logic [2:0][31:0]       normal_out;
    logic [11:0]            material_out;
    logic                   restart_out;
    logic                   busy_out;
    logic                   done_out;

    modport slave (
        input  start_in, index_count_in, matrix_in, ready_in, idx_data_in, vtx_data_in,
        output idx_addr_out, vtx_addr_out, col_set_out, col_out, valid_out,
               position_out, normal_out, material_out, restart_out, busy_out, done_out
    );

    modport master (
        output start_in, index_count_in, matrix_in, ready_in, idx_data_in, vtx_data_in,
        input  idx_addr_out, vtx_addr_out, col_set_out, col_out, valid_out,
               position_out, normal_out, material_out, restart_out, busy_out, done_out
    );
endinterface

// File: rtl/vertex_fetch.sv
// Draw-call front end: loads the transform into the shader, then streams indexed vertices.
// Optional primitive-restart markers (index all ones) are enabled by VERTEX_FETCH_RESTART_EN.
module vertex_fetch #(
    parameter int INDEX_DEPTH  = 4096,
    parameter int VERTEX_DEPTH = 4096,
    parameter int BRAM_LATENCY = 2
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    vertex_fetch_if.slave   bus
);
    localparam int IA = $clog2(INDEX_DEPTH);
    localparam int VA = $clog2(VERTEX_DEPTH);
    localparam int L  = BRAM_LATENCY;
    localparam int D  = 2 * L + 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MATRIX = 2'd1;
    localparam logic [1:0] S_FETCH  = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    logic [1:0]             r_state;
    logic [1:0]             r_col;
    logic [IA:0]            r_count;
    logic [IA:0]            r_k;
    logic [3:0][3:0][31:0]  r_matrix;
    logic [D-1:0]           r_trk;
    logic [D-1:0]           w_trk_next;
    logic                   r_col_set;
    logic [3:0][31:0]       r_col_out;
    logic [IA-1:0]          r_idx_addr;
    logic [VA-1:0]          r_vtx_addr;
    logic                   r_valid;
    logic [2:0][31:0]       r_position;
    logic [2:0][31:0]       r_normal;
    logic [11:0]            r_material;
    logic                   r_done;

    logic w_issue;
    logic w_last;
    logic w_mark;
    logic w_inflight;

    assign w_issue = (r_state == S_FETCH) && bus.ready_in;
    assign w_last  = ((r_k + {{IA{1'b0}}, 1'b1}) == r_count);

`ifdef VERTEX_FETCH_RESTART_EN
    // Restart markers travel in their own lane from the index-data stage onward.
    logic [D-1:L+1] r_rst;
    logic           r_restart;

    assign w_mark     = r_trk[L] && (bus.idx_data_in == {VA{1'b1}});
    assign w_inflight = (|r_trk) || (|r_rst);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rst     <= '0;
            r_restart <= 1'b0;
        end else begin
            r_rst     <= {r_rst[D-2:L+1], w_mark};
            r_restart <= r_rst[D-1];
        end
    end

    assign bus.restart_out = r_restart;
`else
    assign w_mark          = 1'b0;
    assign w_inflight      = |r_trk;
    assign bus.restart_out = 1'b0;
`endif

    // Tracker bit j is set while an issued slot is j cycles into the BRAM pipeline.
    genvar gi;
    assign w_trk_next[0] = w_issue;
    generate
        for (gi = 1; gi < D; gi++) begin : g_trk
            if (gi == L + 1) begin : g_mark
                assign w_trk_next[gi] = r_trk[gi-1] & ~w_mark;
            end else begin : g_shift
                assign w_trk_next[gi] = r_trk[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= S_IDLE;
            r_col      <= 2'd0;
            r_count    <= '0;
            r_k        <= '0;
            r_matrix   <= '0;
            r_col_set  <= 1'b0;
            r_col_out  <= '0;
            r_idx_addr <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_col_set <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A start arriving alongside the done pulse belongs to the finished draw.
                    if (bus.start_in && !r_done) begin
                        r_count   <= bus.index_count_in;
                        r_matrix  <= bus.matrix_in;
                        r_k       <= '0;
                        r_col_set <= 1'b1;
                        r_col_out <= bus.matrix_in[0];
                        r_col     <= 2'd1;
                        r_state   <= S_MATRIX;
                    end
                end
                S_MATRIX: begin
                    r_col_set <= 1'b1;
                    r_col_out <= r_matrix[r_col];
                    r_col     <= r_col + 2'd1;
                    if (r_col == 2'd3) begin
                        r_state <= (r_count == '0) ? S_DRAIN : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.ready_in) begin
                        r_idx_addr <= r_k[IA-1:0];
                        r_k        <= r_k + {{IA{1'b0}}, 1'b1};
                        if (w_last) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                default: begin
                    if (!w_inflight) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_trk      <= '0;
            r_vtx_addr <= '0;
            r_valid    <= 1'b0;
            r_position <= '0;
            r_normal   <= '0;
            r_material <= '0;
        end else begin
            r_trk   <= w_trk_next;
            r_valid <= r_trk[D-1];
            if (r_trk[L] && !w_mark) begin
                r_vtx_addr <= bus.idx_data_in;
            end
            if (r_trk[D-1]) begin
                r_position <= bus.vtx_data_in[95:0];
                r_normal   <= bus.vtx_data_in[191:96];
                r_material <= bus.vtx_data_in[203:192];
            end
        end
    end

    assign bus.idx_addr_out = r_idx_addr;
    assign bus.vtx_addr_out = r_vtx_addr;
    assign bus.col_set_out  = r_col_set;
    assign bus.col_out      = r_col_out;
    assign bus.valid_out    = r_valid;
    assign bus.position_out = r_position;
    assign bus.normal_out   = r_normal;
    assign bus.material_out = r_material;
    assign bus.busy_out     = (r_state != S_IDLE);
    assign bus.done_out     = r_done;
endmodule

// File: tb/tb_vertex_fetch.sv
// Directed bench for vertex_fetch at L=2 with behavioural index/vertex BRAMs.
module tb_vertex_fetch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vertex_fetch_if #(.INDEX_DEPTH(4096), .VERTEX_DEPTH(4096)) vif ();

    vertex_fetch #(
        .INDEX_DEPTH (4096),
        .VERTEX_DEPTH(4096),
        .BRAM_LATENCY(2)
    ) dut (
        .clk_in  (clk),
        .rst_n_in(rst_n),
        .bus     (vif)
    );

    // Vertex word for index v: position[j]={10+j,000,v}, normal[j]={20+j,000,v}, material=v^A5A.
    function automatic logic [203:0] vword(input logic [11:0] v);
        logic [2:0][31:0] p;
        logic [2:0][31:0] n;
        for (int j = 0; j < 3; j++) begin
            p[j] = {8'h10 + 8'(j), 12'h000, v};
            n[j] = {8'h20 + 8'(j), 12'h000, v};
        end
        return {v ^ 12'hA5A, n, p};
    endfunction

    logic [11:0]  idx_mem [4096];
    logic [11:0]  ip1, ip2;
    logic [203:0] vp1, vp2;

    always @(posedge clk) begin
        ip1 <= idx_mem[vif.idx_addr_out];
        ip2 <= ip1;
        vp1 <= vword(vif.vtx_addr_out);
        vp2 <= vp1;
    end
    assign vif.idx_data_in = ip2;
    assign vif.vtx_data_in = vp2;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [13:0] seen [$];
    int done_cnt = 0;
    bit valid_nr = 1'b0;

    always @(posedge clk) begin
        if (vif.valid_out || vif.restart_out)
            seen.push_back({vif.restart_out, vif.valid_out, vif.material_out});
        if (vif.done_out)
            done_cnt <= done_cnt + 1;
        if (vif.valid_out && !vif.ready_in)
            valid_nr <= 1'b1;
    end

    logic [31:0] col3_exp [4] = '{32'hC000_0003, 32'hC000_0013, 32'hC000_0023, 32'hC000_0033};
    logic [11:0] t4_mat   [8] = '{12'hA53, 12'hA59, 12'hA54, 12'hA5B, 12'hA5C, 12'hA51, 12'hA5A, 12'hA52};

    task automatic pulse_start(input logic [12:0] cnt);
        vif.start_in       = 1'b1;
        vif.index_count_in = cnt;
        @(negedge clk);
        vif.start_in = 1'b0;
    endtask

    // Waits (bounded) for done; n is the cycle offset from the start cycle.
    task automatic wait_done(input int n0, input int limit, input bit toggle, output int n);
        n = n0;
        while (vif.done_out !== 1'b1 && n < limit) begin
            if (toggle) vif.ready_in = (n % 3 == 0);
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int d0;
        vif.start_in       = 1'b0;
        vif.index_count_in = '0;
        vif.ready_in       = 1'b1;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                vif.matrix_in[c][r] = 32'hC000_0000 | 32'(c * 16 + r);
        for (int i = 0; i < 4096; i++) idx_mem[i] = 12'h000;
        repeat (2) @(negedge clk);

        chk("rst_busy",    vif.busy_out, 0);
        chk("rst_valid",   vif.valid_out, 0);
        chk("rst_done",    vif.done_out, 0);
        chk("rst_colset",  vif.col_set_out, 0);
        chk("rst_idxaddr", vif.idx_addr_out, 0);
        chk("rst_vtxaddr", vif.vtx_addr_out, 0);
        chk("rst_mat",     vif.material_out, 0);
        chk("rst_restart", vif.restart_out, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // count = 0: matrix load only
        seen.delete();
        d0 = done_cnt;
        pulse_start(13'd0);
        for (int k = 1; k <= 6; k++) begin
            if (k <= 4) begin
                chk($sformatf("z_colset%0d", k), vif.col_set_out, 1);
                chk($sformatf("z_col%0d", k), vif.col_out[3], col3_exp[k-1]);
            end
            case (k)
                1: chk("z_busy_hi", vif.busy_out, 1);
                5: begin
                    chk("z_colset_lo", vif.col_set_out, 0);
                    chk("z_done", vif.done_out, 1);
                    chk("z_busy_lo", vif.busy_out, 0);
                end
                6: chk("z_done_lo", vif.done_out, 0);
                default: ;
            endcase
            @(negedge clk);
        end
        chk("z_no_valid", seen.size(), 0);
        chk("z_done_cnt", done_cnt - d0, 1);

        // count = 4, indices {5,2,2,7}, ready held high
        idx_mem[0] = 12'd5; idx_mem[1] = 12'd2; idx_mem[2] = 12'd2; idx_mem[3] = 12'd7;
        seen.delete();
        d0 = done_cnt;
        pulse_start(13'd4);
        for (int k = 1; k <= 16; k++) begin
            case (k)
                5:  chk("a_idx0", vif.idx_addr_out, 0);
                6:  chk("a_idx1", vif.idx_addr_out, 1);
                8:  chk("a_vtx0", vif.vtx_addr_out, 5);
                10: chk("a_valid_early", vif.valid_out, 0);
                11: begin
                    chk("a_valid0", vif.valid_out, 1);
                    chk("a_mat0", vif.material_out, 12'hA5F);
                    chk("a_pos0", vif.position_out[0], 32'h1000_0005);
                end
                12: chk("a_mat1", vif.material_out, 12'hA58);
                13: begin
                    chk("a_valid2", vif.valid_out, 1);
                    chk("a_nrm2", vif.normal_out[2], 32'h2200_0002);
                end
                14: begin
                    chk("a_mat3", vif.material_out, 12'hA5D);
                    chk("a_pos3", vif.position_out[2], 32'h1200_0007);
                end
                15: begin
                    chk("a_valid_end", vif.valid_out, 0);
                    chk("a_done", vif.done_out, 1);
                    chk("a_hold", vif.material_out, 12'hA5D);
                end
                16: chk("a_done_lo", vif.done_out, 0);
                default: ;
            endcase
            @(negedge clk);
        end
        chk("a_count", seen.size(), 4);
        chk("a_done_cnt", done_cnt - d0, 1);

        // count = 8 with ready toggling 1,0,0
        idx_mem[0] = 12'd9;  idx_mem[1] = 12'd3; idx_mem[2] = 12'd14; idx_mem[3] = 12'd1;
        idx_mem[4] = 12'd6;  idx_mem[5] = 12'd11; idx_mem[6] = 12'd0; idx_mem[7] = 12'd8;
        seen.delete();
        d0 = done_cnt;
        pulse_start(13'd8);
        wait_done(1, 120, 1'b1, n);
        chk("b_done_seen", vif.done_out, 1);
        vif.ready_in = 1'b1;
        repeat (2) @(negedge clk);
        chk("b_count", seen.size(), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("b_vtx%0d", i), (seen.size() > i) ? seen[i] : 14'h0, {2'b01, t4_mat[i]});
        chk("b_valid_while_not_ready", valid_nr, 1);
        chk("b_done_cnt", done_cnt - d0, 1);

        // start while busy and coincident with done must be ignored
        seen.delete();
        d0 = done_cnt;
        pulse_start(13'd2);
        @(negedge clk);
        vif.start_in = 1'b1;
        vif.index_count_in = 13'd5;
        @(negedge clk);
        vif.start_in = 1'b0;
        wait_done(3, 60, 1'b0, n);
        chk("c_done_at", n, 13);
        vif.start_in = 1'b1;
        vif.index_count_in = 13'd5;
        @(negedge clk);
        vif.start_in = 1'b0;
        chk("c_busy_after", vif.busy_out, 0);
        chk("c_colset_after", vif.col_set_out, 0);
        repeat (20) @(negedge clk);
        chk("c_count", seen.size(), 2);
        chk("c_done_cnt", done_cnt - d0, 1);

        // reset mid-FETCH after three issues, then a normal draw
        idx_mem[8] = 12'd20; idx_mem[9] = 12'd21;
        seen.delete();
        d0 = done_cnt;
        pulse_start(13'd10);
        repeat (6) @(negedge clk);
        chk("r_idx_before", vif.idx_addr_out, 2);
        rst_n = 1'b0;
        #1;
        chk("r_idx_zero", vif.idx_addr_out, 0);
        chk("r_busy_zero", vif.busy_out, 0);
        chk("r_vtx_zero", vif.vtx_addr_out, 0);
        chk("r_valid_zero", vif.valid_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("r_no_vertices", seen.size(), 0);
        chk("r_no_done", done_cnt - d0, 0);
        pulse_start(13'd2);
        wait_done(1, 60, 1'b0, n);
        chk("r2_done_at", n, 13);
        repeat (3) @(negedge clk);
        chk("r2_count", seen.size(), 2);
        chk("r2_vtx0", (seen.size() > 0) ? seen[0] : 14'h0, {2'b01, 12'hA53});
        chk("r2_vtx1", (seen.size() > 1) ? seen[1] : 14'h0, {2'b01, 12'hA59});

        // all-ones index: restart marker or ordinary vertex 4095
        idx_mem[0] = 12'd1; idx_mem[1] = 12'hFFF; idx_mem[2] = 12'd3;
        seen.delete();
        pulse_start(13'd3);
        wait_done(1, 60, 1'b0, n);
        chk("m_done_at", n, 14);
        repeat (2) @(negedge clk);
        chk("m_count", seen.size(), 3);
        chk("m_slot0", (seen.size() > 0) ? seen[0] : 14'h0, {2'b01, 12'hA5B});
`ifdef VERTEX_FETCH_RESTART_EN
        chk("m_slot1", (seen.size() > 1) ? seen[1] : 14'h0, {2'b10, 12'hA5B});
`else
        chk("m_slot1", (seen.size() > 1) ? seen[1] : 14'h0, {2'b01, 12'h5A5});
`endif
        chk("m_slot2", (seen.size() > 2) ? seen[2] : 14'h0, {2'b01, 12'hA59});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vertex_fetch.md
# vertex_fetch

Draw-call front end feeding `vertex_shader`.
- On a start pulse it latches a 4x4 transform matrix and streams its four columns into the shader's column-load port.
- It then walks an index buffer and fetches each referenced vertex (position, normal, material) from the vertex BRAM.
- It presents one vertex per cycle on the shader's input port, and signals completion once the last fetched vertex has left.

## Interface
- `INDEX_DEPTH`, 4096: index buffer entries; index address width `IA = $clog2(INDEX_DEPTH)`.
- `VERTEX_DEPTH`, 4096: vertex BRAM entries; vertex index width `VA = $clog2(VERTEX_DEPTH)`.
- `BRAM_LATENCY`, 2: cycles from address on a BRAM port to data valid (L below); range 1–4.
- `clk_in  in  1`: clock.
- `rst_n_in  in  1`: reset, asynchronous and active-low.
- `start_in  in  1`: single-cycle draw request; sampled only in IDLE.
- `index_count_in  in  IA+1`: number of indices to process; latched with start.
- `matrix_in  in  [3:0][3:0][31:0]`: transform; `matrix_in[c]` is column c, fp32; latched with start.
- `ready_in  in  1`: downstream may accept new issues; gates issue only.
- `idx_addr_out  out  IA`: index BRAM read address.
- `idx_data_in  in  VA`: index BRAM read data.
- `vtx_addr_out  out  VA`: vertex BRAM read address.
- `vtx_data_in  in  204`: packed as {material[11:0], normal[2:0][31:0], position[2:0][31:0]}, LSB first.
- `col_set_out  out  1`, `col_out  out  [3:0][31:0]`: matrix column load.
- `valid_out  out  1`, `position_out  out  [2:0][31:0]`, `normal_out  out  [2:0][31:0]`, `material_out  out  12`: vertex to the shader.
- `restart_out  out  1`: primitive-restart marker (see Configuration).
- `busy_out  out  1`: high in any state other than IDLE.
- `done_out  out  1`: one-cycle completion pulse.

## Operation
- States: IDLE, MATRIX, FETCH, DRAIN.
- **IDLE**
  - On `start_in`: latch count and matrix, clear the issue counter, go to MATRIX.
- **MATRIX**
  - Four consecutive cycles with `col_set_out`=1 and `col_out` = column 0, 1, 2, 3 in order.
  - Then go to FETCH, or to DRAIN if count = 0.
- **FETCH**
  - Each cycle with `ready_in`=1: issue index address k (k = 0..count-1), then k++.
  - With `ready_in`=0: nothing is issued and k holds.
  - After issuing index count-1, go to DRAIN.
- **DRAIN**
  - Wait until the in-flight tracker is empty.
  - Pulse `done_out` for one cycle, return to IDLE.
- In-flight tracker: shift register of depth 2L+2 carrying issue-valid bits alongside the pipeline. It is also what qualifies `valid_out`.
- `start_in` outside IDLE is ignored. A `start_in` in the same cycle as the `done_out` pulse is also ignored.
- Addresses wrap never: k < count ≤ INDEX_DEPTH.
- Index values ≥ VERTEX_DEPTH cannot occur, because VA is sized to the vertex BRAM.

## Timing
- Reset, asserted asynchronously at any time, including mid-draw:
  - State returns to IDLE; the tracker and issue counter clear.
  - All outputs, including addresses and data, go to 0.
  - In-flight vertices are discarded, with no `done_out`.
- Issue in cycle t drives `idx_addr_out`=k (registered) at t.
- `idx_data_in` is valid at t+L.
- `vtx_addr_out` is registered from `idx_data_in` and visible at t+L+1.
- `vtx_data_in` is valid at t+2L+1.
- Output registers load at t+2L+2: `valid_out`=1 with unpacked fields. Latency is 2L+2, i.e. 6 cycles at L=2.
- `valid_out` is a single-cycle pulse per vertex. Data outputs hold their last value when `valid_out`=0.
- Throughput is one vertex per cycle while `ready_in`=1.
- Dropping `ready_in` does not stall in-flight vertices. Downstream must absorb up to 2L+2 vertices after deasserting `ready_in`.
- First issue happens the cycle after the 4th `col_set_out`.
- `done_out` fires exactly one cycle after the final `valid_out` (or `restart_out`). For count = 0 it fires 1 cycle after the last `col_set_out`.
- `busy_out` rises the cycle after the accepted start and falls with `done_out`.

## Configuration
- `VERTEX_FETCH_RESTART_EN`
  - Defined:
    - An index value of all ones (`{VA{1'b1}}`) is a restart marker. No vertex fetch is made for it.
    - In the slot where its `valid_out` would have occurred, `restart_out`=1 and `valid_out`=0.
    - The marker still counts toward `index_count_in`.
  - Undefined:
    - All-ones is an ordinary vertex index.
    - `restart_out` is tied to 0.

## Test plan
- Reset mid-FETCH, with count=10, asserted after 3 issues → outputs 0 immediately, no `done_out`. A subsequent start with count=2 completes normally.
- Start with a distinct matrix, count=0 → `col_set_out` high for 4 cycles with columns 0..3 in order, then `done_out` 1 cycle after the last. No `valid_out`.
- Count=4, indices {5,2,2,7}, `ready_in`=1, L=2:
  - First `valid_out` 6 cycles after first issue, then 4 consecutive vertices matching BRAM entries 5, 2, 2, 7.
  - `done_out` 1 cycle after the 4th vertex.
- Count=8 with `ready_in` toggled 1,0,0,1,...:
  - All 8 vertices emitted in index order with no duplicates.
  - In-flight vertices continue while `ready_in`=0.
- `start_in` pulsed while busy, and again coincident with `done_out` → ignored. Exactly one draw is performed.
- With `VERTEX_FETCH_RESTART_EN`, indices {1,12'hFFF,3} → `valid_out` for 1 and 3, `restart_out` in the middle slot, `done_out` after slot 3. Without the macro, vertex 4095 is emitted in that slot instead.
